// File: rtl/divider_share_arbiter.sv
// divider_share_arbiter
//   Shares one repeated-subtraction divider between NREQ requesters.
//   A round-robin arbiter picks a requester. The sequencer then loads the
//   divisor and the dividend over the divider's shared data bus, pulses
//   start and waits for done. The quotient goes back to the winner on a
//   valid/ready response channel. Only one transaction is in flight.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req[NREQ]                   request levels, held until granted
//   req_dividend/req_divisor    flat operands, requester i at [i*W +: W]
//   gnt[NREQ]                   one-hot, 1-cycle pulse when operands are captured
//   busy                        high whenever the sequencer is not idle
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/rsp_quot/rsp_err     served requester, quotient, error flag
//   div_data/div_lda/div_ldb    shared load bus and load strobes to the divider
//   div_start                   1-cycle start pulse to the divider
//   div_done/div_quot           divider completion and result
module divider_share_arbiter #(
  parameter int W       = 5,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_dividend,
  input  logic [NREQ*W-1:0] req_divisor,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_id,
  output logic [W-1:0]      rsp_quot,
  output logic              rsp_err,
  output logic [W-1:0]      div_data,
  output logic              div_lda,
  output logic              div_ldb,
  output logic              div_start,
  input  logic              div_done,
  input  logic [W-1:0]      div_quot
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      rr_ptr, rr_nxt, pick, id_q;
  logic [7:0]      timer;
  logic            err_q;
  logic [W-1:0]    divisor_q, dividend_q, quot_q;
  logic [W-1:0]    sel_divisor, sel_dividend;
  logic [NREQ-1:0] gnt_c;
  logic            any_req, timeout_hit, grant_now;

  // First requester at or after ptr, wrapping. The request vector is doubled
  // and rotated so the search is a plain lowest-set-bit scan.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r,
                                         input logic [2:0]      ptr);
    logic [2*NREQ-1:0] rot;
    logic [3:0]        idx;
    logic              found;
    logic [2:0]        sel;
    rot   = {r, r} >> ptr;
    idx   = {1'b0, ptr};
    found = 1'b0;
    sel   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[0]) begin
        found = 1'b1;
        sel   = idx[2:0];
      end
      rot = rot >> 1;
      idx = (idx == 4'(NREQ - 1)) ? 4'd0 : idx + 4'd1;
    end
    return sel;
  endfunction

  assign any_req      = |req;
  assign pick         = rr_pick(req, rr_ptr);
  assign rr_nxt       = (pick == 3'(NREQ - 1)) ? 3'd0 : pick + 3'd1;
  assign sel_divisor  = W'(req_divisor >> (int'(pick) * W));
  assign sel_dividend = W'(req_dividend >> (int'(pick) * W));
  assign grant_now    = (state == IDLE) && any_req;
  // WAIT gives up after TIMEOUT cycles; the timer is 0 on the first WAIT cycle.
  assign timeout_hit  = (9'(timer) + 9'd1) == 9'(TIMEOUT);

  always_comb begin
    state_nxt = state;
    gnt_c     = '0;
    div_data  = '0;
    div_lda   = 1'b0;
    div_ldb   = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_c     = NREQ'(1'b1) << pick;
          state_nxt = (sel_divisor == '0) ? RESP : LOAD_A;
        end
      end
      LOAD_A: begin
        div_data  = divisor_q;
        div_lda   = 1'b1;
        state_nxt = LOAD_B;
      end
      LOAD_B: begin
        div_data  = dividend_q;
        div_ldb   = 1'b1;
        state_nxt = START;
      end
      START: begin
        div_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (div_done || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are masked by reset so every output is 0 while rst_n is low,
  // even with requests pending.
  assign gnt       = gnt_c & {NREQ{rst_n}};
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_id    = rsp_valid ? id_q   : 3'd0;
  assign rsp_quot  = rsp_valid ? quot_q : '0;
  assign rsp_err   = rsp_valid ? err_q  : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= 3'd0;
      timer  <= 8'd0;
      id_q   <= 3'd0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_now) begin
        rr_ptr <= rr_nxt;
        id_q   <= pick;
        err_q  <= (sel_divisor == '0);
      end
      if (state == START) timer <= 8'd0;
      if (state == WAIT) begin
        timer <= timer + 8'd1;
        if (div_done)         err_q <= 1'b0;
        else if (timeout_hit) err_q <= 1'b1;
      end
    end
  end

  // Operand and result holding registers carry no reset: they are only
  // observed through the state-gated outputs above.
  always_ff @(posedge clk) begin
    if (grant_now) begin
      divisor_q  <= sel_divisor;
      dividend_q <= sel_dividend;
      quot_q     <= '0;
    end else if (state == WAIT) begin
      if (div_done)         quot_q <= div_quot;
      else if (timeout_hit) quot_q <= '0;
    end
  end

endmodule

// File: tb/tb_divider_share_arbiter.sv
module tb_divider_share_arbiter;
  localparam int W       = 5;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_dividend = '0;
  logic [NREQ*W-1:0] req_divisor = '0;
  logic              rsp_ready = 1'b0;
  logic              div_done = 1'b0;
  logic [W-1:0]      div_quot = '0;
  logic [NREQ-1:0]   gnt;
  logic              busy, rsp_valid, rsp_err, div_lda, div_ldb, div_start;
  logic [2:0]        rsp_id;
  logic [W-1:0]      rsp_quot, div_data;

  divider_share_arbiter #(.W(W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dividend(req_dividend),
    .req_divisor(req_divisor), .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_quot(rsp_quot), .rsp_err(rsp_err),
    .div_data(div_data), .div_lda(div_lda), .div_ldb(div_ldb), .div_start(div_start),
    .div_done(div_done), .div_quot(div_quot)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester operands, packed onto the flat buses by pack().
  logic [W-1:0] dvd_a [NREQ];
  logic [W-1:0] dvs_a [NREQ];

  task automatic pack();
    req_dividend = '0;
    req_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_dividend |= (NREQ*W)'(dvd_a[i]) << (i * W);
      req_divisor  |= (NREQ*W)'(dvs_a[i]) << (i * W);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // A transaction is described by its age t (cycles since grant) and the age
  // at which its response becomes visible.
  bit           m_active = 0;
  int           m_t, m_resp_at, m_rr = 0, m_id;
  logic [W-1:0] m_dvd, m_dvs, m_quot;
  logic         m_err;

  function automatic int first_from(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    logic [NREQ-1:0] e_gnt;
    logic            e_busy, e_lda, e_ldb, e_start, e_valid;
    logic [W-1:0]    e_data;
    int              w;
    if (!rst_n) begin
      chk("reset_outputs", {gnt, busy, rsp_valid, div_lda, div_ldb, div_start,
                            div_data, rsp_quot, rsp_id, rsp_err}, 0);
      m_active = 0;
      m_rr     = 0;
    end else begin
      e_gnt = '0; e_busy = 0; e_lda = 0; e_ldb = 0; e_start = 0; e_valid = 0;
      e_data = '0; w = -1;
      if (!m_active) begin
        w = first_from(req, m_rr);
        if (w >= 0) e_gnt = NREQ'(1) << w;
      end else begin
        e_busy  = 1;
        e_valid = (m_resp_at >= 0) && (m_t >= m_resp_at);
        if (m_dvs != 0) begin
          if (m_t == 1) begin e_lda = 1; e_data = m_dvs; end
          if (m_t == 2) begin e_ldb = 1; e_data = m_dvd; end
          if (m_t == 3) e_start = 1;
          if (m_t >= 4 && m_resp_at < 0) begin
            if (div_done) begin
              m_resp_at = m_t + 1; m_quot = m_dvd / m_dvs; m_err = 0;
            end else if (m_t - 3 == TIMEOUT) begin
              m_resp_at = m_t + 1; m_quot = '0; m_err = 1;
            end
          end
        end
      end
      chk("gnt", gnt, e_gnt);
      chk("busy", busy, e_busy);
      chk("div_lda", div_lda, e_lda);
      chk("div_ldb", div_ldb, e_ldb);
      chk("div_start", div_start, e_start);
      chk("div_data", div_data, e_data);
      chk("rsp_valid", rsp_valid, e_valid);
      if (e_valid) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_quot", rsp_quot, m_quot);
        chk("rsp_err", rsp_err, m_err);
      end
      if (m_active) begin
        if (e_valid && rsp_ready) m_active = 0;
        else m_t++;
      end else if (w >= 0) begin
        m_active  = 1;
        m_t       = 1;
        m_id      = w;
        m_dvd     = dvd_a[w];
        m_dvs     = dvs_a[w];
        m_quot    = '0;
        m_err     = (dvs_a[w] == 0);
        m_resp_at = (dvs_a[w] == 0) ? 1 : -1;
        m_rr      = (w + 1) % NREQ;
      end
    end
  end

  // ---------------- environment: requesters, response sink, divider ----------------
  bit  auto_req = 0, spurious = 0;
  int  p_req = 0, p_drop = 0, p_rdy = 100, done_mode = 2, dcnt = -1;
  int  ncyc = 0, g_cyc = 0, lda_cyc = 0, ldb_cyc = 0, st_cyc = 0, fv_cyc = 0;
  int  n_lda = 0, n_start = 0, n_valid = 0, n_acc = 0;
  int  gq[$];
  logic [NREQ-1:0] g_s;
  logic            st_s, pv = 0;
  logic [W-1:0]    a_lat = '0, b_lat = '0, r_quot;
  logic [2:0]      r_id;
  logic            r_err;

  task automatic cycle();
    @(negedge clk);
    ncyc++;
    if (gnt != 0) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gq.push_back(i);
      g_cyc = ncyc;
    end
    g_s = gnt;
    if (div_lda) begin a_lat = div_data; lda_cyc = ncyc; n_lda++; end
    if (div_ldb) begin b_lat = div_data; ldb_cyc = ncyc; end
    if (div_start) begin st_cyc = ncyc; n_start++; end
    st_s = div_start;
    if (rsp_valid) begin
      n_valid++; r_id = rsp_id; r_quot = rsp_quot; r_err = rsp_err;
      if (!pv) fv_cyc = ncyc;
    end
    pv = rsp_valid;
    if (rsp_valid && rsp_ready) n_acc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (g_s[i]) req[i] = 1'b0;
      if (auto_req) begin
        if (!req[i]) begin
          dvd_a[i] = W'($urandom);
          dvs_a[i] = ($urandom % 5 == 0) ? '0 : W'($urandom);
          if ($urandom % 100 < p_req) req[i] = 1'b1;
        end else if ($urandom % 100 < p_drop) begin
          req[i] = 1'b0;
        end
      end
    end
    pack();
    rsp_ready = ($urandom % 100) < p_rdy;
    div_done  = 1'b0;
    if (st_s) dcnt = (done_mode == 0) ? int'($urandom % 5) : ((done_mode == 2) ? 0 : -1);
    if (dcnt == 0) begin div_done = 1'b1; dcnt = -1; end
    else if (dcnt > 0) dcnt--;
    else if (spurious && $urandom % 8 == 0) div_done = 1'b1;
    div_quot = (a_lat != 0) ? b_lat / a_lat : '0;
  endtask

  task automatic run_acc(input int maxc, input string nm);
    int a0;
    bit ok;
    a0 = n_acc;
    ok = 0;
    for (int k = 0; k < maxc; k++) begin
      cycle();
      if (n_acc > a0) begin ok = 1; break; end
    end
    if (!ok) chk({nm, "_no_response"}, 0, 1);
  endtask

  initial begin : main
    int l0, s0, g0, v0;
    bit seen;
    for (int i = 0; i < NREQ; i++) begin dvd_a[i] = '0; dvs_a[i] = '0; end
    pack();
    repeat (3) cycle();
    rst_n = 1'b1;

    // Single request 15/2 with a divider that finishes in its first WAIT cycle.
    dvd_a[0] = 5'd15; dvs_a[0] = 5'd2; pack(); req = 4'b0001;
    run_acc(40, "t1");
    chk("t1_lda_lat", lda_cyc - g_cyc, 1);
    chk("t1_lda_data", a_lat, 2);
    chk("t1_ldb_lat", ldb_cyc - g_cyc, 2);
    chk("t1_ldb_data", b_lat, 15);
    chk("t1_start_lat", st_cyc - g_cyc, 3);
    chk("t1_rsp_lat", fv_cyc - g_cyc, 5);
    chk("t1_id", r_id, 0);
    chk("t1_quot", r_quot, 7);
    chk("t1_err", r_err, 0);

    // Divide by zero: response one cycle after grant, divider untouched.
    l0 = n_lda; s0 = n_start;
    dvd_a[2] = 5'd9; dvs_a[2] = 5'd0; pack(); req = 4'b0100;
    run_acc(20, "t3");
    chk("t3_rsp_lat", fv_cyc - g_cyc, 1);
    chk("t3_id", r_id, 2);
    chk("t3_err", r_err, 1);
    chk("t3_quot", r_quot, 0);
    chk("t3_no_load", n_lda - l0, 0);
    chk("t3_no_start", n_start - s0, 0);

    // Divider never finishes: timeout abort.
    done_mode = 1;
    dvd_a[1] = 5'd10; dvs_a[1] = 5'd3; pack(); req = 4'b0010;
    run_acc(400, "t4");
    chk("t4_timeout_lat", fv_cyc - st_cyc, 256);
    chk("t4_id", r_id, 1);
    chk("t4_err", r_err, 1);
    chk("t4_quot", r_quot, 0);
    done_mode = 2;

    // Back-pressure: response held, no new grant until accepted.
    p_rdy = 0;
    dvd_a[0] = 5'd20; dvs_a[0] = 5'd6; pack(); req = 4'b0001;
    v0 = n_valid; seen = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (n_valid > v0) begin seen = 1; break; end
    end
    if (!seen) chk("t5_no_valid", 0, 1);
    dvd_a[3] = 5'd7; dvs_a[3] = 5'd7; pack(); req[3] = 1'b1;
    g0 = gq.size(); v0 = n_valid;
    repeat (10) cycle();
    chk("t5_no_gnt", gq.size() - g0, 0);
    chk("t5_valid_held", n_valid - v0, 10);
    chk("t5_id", r_id, 0);
    chk("t5_quot", r_quot, 3);
    p_rdy = 100;
    run_acc(5, "t5a");
    run_acc(20, "t5b");
    chk("t5_next_id", r_id, 3);
    chk("t5_next_quot", r_quot, 1);

    // Fairness with all requests held.
    rst_n = 1'b0; repeat (2) cycle(); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      dvd_a[i] = W'($urandom); dvs_a[i] = W'(1 + $urandom % 31);
    end
    pack(); req = '1;
    auto_req = 1; p_req = 100; p_drop = 0;
    g0 = gq.size();
    for (int k = 0; k < 300 && gq.size() < g0 + 5; k++) cycle();
    if (gq.size() >= g0 + 5) begin
      for (int k = 0; k < 5; k++) chk($sformatf("t2_order%0d", k), gq[g0 + k], k % NREQ);
    end else begin
      chk("t2_grant_count", gq.size() - g0, 5);
    end
    auto_req = 0;
    repeat (100) cycle();

    // Reset in the middle of WAIT.
    done_mode = 1;
    dvd_a[0] = 5'd12; dvs_a[0] = 5'd4; pack(); req = 4'b0001;
    s0 = n_start;
    for (int k = 0; k < 30 && n_start == s0; k++) cycle();
    repeat (3) cycle();
    for (int i = 0; i < NREQ; i++) begin dvd_a[i] = 5'd8; dvs_a[i] = 5'd2; end
    pack(); req = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_valid", rsp_valid, 0);
    chk("t6_gnt", gnt, 0);
    chk("t6_div_ctl", {div_lda, div_ldb, div_start, div_data}, 0);
    chk("t6_rsp", {rsp_id, rsp_quot, rsp_err}, 0);
    done_mode = 2; dcnt = -1;
    repeat (2) cycle();
    rst_n = 1'b1;
    g0 = gq.size();
    cycle();
    chk("t6_first_after_reset", (gq.size() > g0) ? gq[g0] : 99, 0);
    repeat (60) cycle();

    // Randomised traffic.
    auto_req = 1; p_req = 30; p_drop = 3; p_rdy = 60; done_mode = 0; spurious = 1;
    repeat (3000) cycle();
    auto_req = 0; spurious = 0; p_rdy = 100; done_mode = 2;
    repeat (80) cycle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
